// File: rtl/control32_pkg.sv
// Shared opcode/funct constants, FSM state encoding and decode bundle for the
// multi-cycle MIPS control unit.
package control32_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  typedef struct packed {
    logic r_format;
    logic i_format;
    logic jr;
    logic jmp;
    logic jal;
    logic branch;
    logic nbranch;
    logic lw;
    logic sw;
    logic reg_dst;
    logic alu_src;
    logic sftmd;
  } decode_t;

  // sll, srl, sra, sllv, srlv, srav
  function automatic logic is_shift_funct(input logic [5:0] fn);
    logic hit;
    case (fn)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: hit = 1'b1;
      default:                                  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/control32_multicycle_if.sv
// Bus between the control unit (slave) and the datapath/memory side (master).
interface control32_multicycle_if #(
  parameter int ADDR_HI_W = 22
);
  logic [5:0]           Opcode;
  logic [5:0]           Function_opcode;
  logic [ADDR_HI_W-1:0] Alu_resultHigh;
  logic                 mem_ready;
  logic                 io_ready;

  logic       PCWrite, IRWrite;
  logic       Jr, Jmp, Jal, Branch, nBranch, I_format, Sftmd, RegDST, ALUSrc;
  logic [1:0] ALUOp;
  logic       RegWrite, MemWrite, MemRead, IORead, IOWrite, MemorIOtoReg;
  logic       io_timeout;
  logic [2:0] state;

  modport slave (
    input  Opcode, Function_opcode, Alu_resultHigh, mem_ready, io_ready,
    output PCWrite, IRWrite, Jr, Jmp, Jal, Branch, nBranch, I_format, Sftmd,
           RegDST, ALUSrc, ALUOp, RegWrite, MemWrite, MemRead, IORead, IOWrite,
           MemorIOtoReg, io_timeout, state
  );

  modport master (
    output Opcode, Function_opcode, Alu_resultHigh, mem_ready, io_ready,
    input  PCWrite, IRWrite, Jr, Jmp, Jal, Branch, nBranch, I_format, Sftmd,
           RegDST, ALUSrc, ALUOp, RegWrite, MemWrite, MemRead, IORead, IOWrite,
           MemorIOtoReg, io_timeout, state
  );

endinterface

// File: rtl/control32_decode.sv
// Purely combinational instruction decode: Opcode/Function_opcode -> decode bundle.
module control32_decode
  import control32_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output decode_t    dec_o
);

  logic r_s;
  logic i_s;
  logic lw_s;
  logic sw_s;

  assign r_s  = (opcode_i == OP_RTYPE);
  assign i_s  = (opcode_i[5:3] == 3'b001);
  assign lw_s = (opcode_i == OP_LW);
  assign sw_s = (opcode_i == OP_SW);

  assign dec_o.r_format = r_s;
  assign dec_o.i_format = i_s;
  assign dec_o.jr       = r_s && (funct_i == FN_JR);
  assign dec_o.jmp      = (opcode_i == OP_J);
  assign dec_o.jal      = (opcode_i == OP_JAL);
  assign dec_o.branch   = (opcode_i == OP_BEQ);
  assign dec_o.nbranch  = (opcode_i == OP_BNE);
  assign dec_o.lw       = lw_s;
  assign dec_o.sw       = sw_s;
  assign dec_o.reg_dst  = r_s;
  assign dec_o.alu_src  = i_s | lw_s | sw_s;
  assign dec_o.sftmd    = r_s && is_shift_funct(funct_i);

endmodule

// File: rtl/control32_multicycle.sv
// Multi-cycle control FSM (IF/ID/EX/MEM/WB): latches decode, stretches lw/sw until
// RAM or MMIO answers, and aborts a MEM access after IO_WAIT_MAX idle cycles.
module control32_multicycle
  import control32_pkg::*;
#(
  parameter int                   ADDR_HI_W   = 22,
  parameter logic [ADDR_HI_W-1:0] MEM_HI_VAL  = {ADDR_HI_W{1'b1}},
  parameter int                   IO_WAIT_MAX = 15,
  parameter int                   CNT_W       = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  control32_multicycle_if.slave bus
);

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(IO_WAIT_MAX);

  state_e           state_q, state_d;
  logic             run_q;
  decode_t          dec_s, dec_q, dec_d;
  logic             mem_sel_q, mem_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_jump_s, is_mem_s, is_wb_s, ready_s, timeout_s;

  logic pc_write_s, ir_write_s, reg_write_s, mem_write_s, mem_read_s;
  logic io_read_s, io_write_s, mem_to_reg_s, io_timeout_s;

  control32_decode u_decode (
    .opcode_i (bus.Opcode),
    .funct_i  (bus.Function_opcode),
    .dec_o    (dec_s)
  );

  assign is_jump_s = dec_q.jmp | dec_q.jr | dec_q.branch | dec_q.nbranch;
  assign is_mem_s  = dec_q.lw | dec_q.sw;
  assign is_wb_s   = dec_q.r_format | dec_q.i_format | dec_q.jal;
  assign ready_s   = mem_sel_q ? bus.mem_ready : bus.io_ready;
  // Ready in the final wait cycle still completes the access.
  assign timeout_s = (cnt_q == WAIT_MAX) && !ready_s;

  // State register; run_q holds IF idle for the first edge after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IF;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF: begin
        if (run_q) state_d = S_ID;
        else       state_d = S_IF;
      end
      S_ID: state_d = S_EX;
      S_EX: begin
        if (is_jump_s)     state_d = S_IF;
        else if (is_mem_s) state_d = S_MEM;
        else if (is_wb_s)  state_d = S_WB;
        else               state_d = S_IF;
      end
      S_MEM: begin
        if (ready_s) begin
          if (dec_q.lw) state_d = S_WB;
          else          state_d = S_IF;
        end else if (timeout_s) begin
          state_d = S_IF;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // Next values for the decode latch, address-space latch and wait counter.
  always_comb begin
    dec_d     = dec_q;
    mem_sel_d = mem_sel_q;
    cnt_d     = cnt_q;
    if (state_q == S_ID) begin
      dec_d = dec_s;
    end else begin
      dec_d = dec_q;
    end
    if (state_q == S_EX) begin
      mem_sel_d = (bus.Alu_resultHigh == MEM_HI_VAL);
      cnt_d     = {CNT_W{1'b0}};
    end else if ((state_q == S_MEM) && !ready_s && !timeout_s) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Decode latch, address-space latch and wait counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dec_q     <= '0;
      mem_sel_q <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      dec_q     <= dec_d;
      mem_sel_q <= mem_sel_d;
      cnt_q     <= cnt_d;
    end
  end

  // State-gated strobes; everything is zero in IF while run_q is low.
  always_comb begin
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    reg_write_s  = 1'b0;
    mem_write_s  = 1'b0;
    mem_read_s   = 1'b0;
    io_read_s    = 1'b0;
    io_write_s   = 1'b0;
    mem_to_reg_s = 1'b0;
    io_timeout_s = 1'b0;
    case (state_q)
      S_IF: ir_write_s = run_q;
      S_ID: ir_write_s = 1'b0;
      S_EX: pc_write_s = is_jump_s | ~(is_mem_s | is_wb_s);
      S_MEM: begin
        mem_read_s   = dec_q.lw &  mem_sel_q;
        io_read_s    = dec_q.lw & ~mem_sel_q;
        mem_to_reg_s = dec_q.lw;
        mem_write_s  = dec_q.sw &  mem_sel_q;
        io_write_s   = dec_q.sw & ~mem_sel_q;
        if (ready_s) begin
          pc_write_s = dec_q.sw;
        end else if (timeout_s) begin
          pc_write_s   = 1'b1;
          io_timeout_s = 1'b1;
        end else begin
          pc_write_s = 1'b0;
        end
      end
      S_WB: begin
        reg_write_s  = ~dec_q.jr;
        mem_to_reg_s = dec_q.lw;
        pc_write_s   = 1'b1;
      end
      default: pc_write_s = 1'b0;
    endcase
  end

  assign bus.PCWrite      = pc_write_s;
  assign bus.IRWrite      = ir_write_s;
  assign bus.RegWrite     = reg_write_s;
  assign bus.MemWrite     = mem_write_s;
  assign bus.MemRead      = mem_read_s;
  assign bus.IORead       = io_read_s;
  assign bus.IOWrite      = io_write_s;
  assign bus.MemorIOtoReg = mem_to_reg_s;
  assign bus.io_timeout   = io_timeout_s;
  assign bus.state        = state_q;

  assign bus.Jr       = dec_q.jr;
  assign bus.Jmp      = dec_q.jmp;
  assign bus.Jal      = dec_q.jal;
  assign bus.Branch   = dec_q.branch;
  assign bus.nBranch  = dec_q.nbranch;
  assign bus.I_format = dec_q.i_format;
  assign bus.Sftmd    = dec_q.sftmd;
  assign bus.RegDST   = dec_q.reg_dst;
  assign bus.ALUSrc   = dec_q.alu_src;
  assign bus.ALUOp    = {dec_q.r_format | dec_q.i_format, dec_q.branch | dec_q.nbranch};

endmodule
